// File: rtl/fifo_burst_arbiter_pkg.sv
// Shared definitions for the FIFO burst arbiter: FSM encoding, header tag and
// default burst/FIFO geometry.
package fifo_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] HDR_TAG        = 8'hA0;
  localparam int         DEF_BURST_LEN  = 8;
  localparam int         DEF_FIFO_DEPTH = 256;

endpackage

// File: rtl/fifo_burst_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping
// modulo NUM_CH, returned both one-hot and as an index.
module rr_pick
  import fifo_burst_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [NUM_CH-1:0] pick_o,
  output logic [CH_W-1:0]   idx_o
);

  logic            found;
  logic [CH_W-1:0] cand;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    cand   = '0;
    // Offsets 1..NUM_CH so the previous owner is searched last.
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(last_i) + 32'(k)) % 32'(NUM_CH));
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        idx_o        = cand;
        pick_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst writer into the shared sample FIFO: one header byte then
// BURST_LEN samples from the granted channel, granted only when the packet fits.
module fifo_burst_arbiter
  import fifo_burst_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*8-1:0]   ch_data,
  output logic [NUM_CH-1:0]     ch_pop,
  input  logic [CNT_W-1:0]      fifo_count,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [7:0]            fifo_din,
  output logic [NUM_CH-1:0]     grant,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  overflow_err
);

  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0] PKT_LEN   = (CNT_W+1)'(BURST_LEN + 1);
  localparam logic [7:0]     LAST_BEAT = 8'(BURST_LEN - 1);

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]     sel_q, sel_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [7:0]          beat_q, beat_d;
  logic                overflow_q;

  logic [NUM_CH-1:0]   pick;
  logic [CH_W-1:0]     pick_idx;
  logic [CNT_W:0]      count_ext;
  logic [CNT_W:0]      free_space;
  logic                space_ok;
  logic                can_grant;
  logic [7:0]          ch_bytes [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_bytes[gi] = ch_data[8*gi +: 8];
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req_i  (req),
    .last_i (last_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  // An out-of-range occupancy would wrap the subtraction, so it counts as full.
  assign count_ext  = {1'b0, fifo_count};
  assign free_space = DEPTH_EXT - count_ext;
  assign space_ok   = (count_ext <= DEPTH_EXT) && (free_space >= PKT_LEN);
  assign can_grant  = enable && (req != '0) && space_ok;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_d     = last_q;
    beat_d     = beat_q;
    fifo_wr_en = 1'b0;
    fifo_din   = 8'h00;
    ch_pop     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          grant_d = pick;
          sel_d   = pick_idx;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        fifo_wr_en = 1'b1;
        fifo_din   = HDR_TAG | 8'(sel_q);
        beat_d     = 8'd0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        fifo_wr_en = 1'b1;
        fifo_din   = ch_bytes[sel_q];
        ch_pop     = grant_q;
        beat_d     = beat_q + 8'd1;
        if (beat_q == LAST_BEAT) state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d  = sel_q;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_q     <= CH_W'(NUM_CH - 1);
      beat_q     <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      if (fifo_wr_en && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign burst_done   = (state_q == ST_DONE);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared cycle by
// cycle against a packet-level reference model.
module tb_fifo_burst_arbiter;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int BL     = 8;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH*8-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_pop;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_wr_en;
  logic [7:0]          fifo_din;
  logic [NUM_CH-1:0]   grant;
  logic                busy;
  logic                burst_done;
  logic                overflow_err;

  fifo_burst_arbiter #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .ch_data(ch_data),
    .ch_pop(ch_pop), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant(grant), .busy(busy),
    .burst_done(burst_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Source samples: channel ch's n-th sample; channel 0 starts at 0x10.
  function automatic logic [7:0] pat(int ch, int n);
    return 8'((ch * 64 + 16 + n) & 255);
  endfunction

  int src_cnt [NUM_CH];
  always_comb begin
    ch_data = '0;
    for (int i = 0; i < NUM_CH; i++) ch_data[8*i +: 8] = pat(i, src_cnt[i]);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: remaining cycles of the current packet (0 = idle).
  int  m_left, m_sel, m_last;
  int  m_cnt [NUM_CH];
  bit  m_ovf;
  int  obs_busy, obs_pop, obs_done, obs_wr;
  logic [7:0] hdr_q [$];

  function automatic bit model_can_grant();
    if (!enable || req == '0) return 1'b0;
    if (int'(fifo_count) > DEPTH) return 1'b0;
    return (DEPTH - int'(fifo_count)) >= BL + 1;
  endfunction

  function automatic int model_pick(int last_ch, logic [NUM_CH-1:0] r);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (last_ch + k) % NUM_CH;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic cycle();
    logic [NUM_CH-1:0] pop_seen;
    logic              e_wr, e_busy, e_done;
    logic [7:0]        e_din;
    logic [NUM_CH-1:0] e_grant, e_pop;
    int                phase;
    @(negedge clk);
    e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_din = 8'h00;
    e_grant = '0; e_pop = '0;
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    if (m_left == 0) begin
      if (model_can_grant()) begin
        m_sel  = model_pick(m_last, req);
        m_left = BL + 2;
      end
    end else begin
      phase   = BL + 2 - m_left;
      e_busy  = 1'b1;
      e_grant = NUM_CH'(1) << m_sel;
      if (phase == 0) begin
        e_wr  = 1'b1;
        e_din = 8'hA0 | 8'(m_sel);
        hdr_q.push_back(fifo_din);
      end else if (phase <= BL) begin
        e_wr  = 1'b1;
        e_din = pat(m_sel, m_cnt[m_sel]);
        e_pop = e_grant;
        m_cnt[m_sel]++;
      end else begin
        e_done = 1'b1;
        m_last = m_sel;
        $display("[TB] packet from ch%0d complete, %0d checks so far", m_sel, n_tests);
      end
      m_left--;
    end
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    if (e_wr) check("fifo_din", 32'(fifo_din), 32'(e_din));
    check("grant", 32'(grant), 32'(e_grant));
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("ch_pop", 32'(ch_pop), 32'(e_pop));
    check("busy", 32'(busy), 32'(e_busy));
    check("burst_done", 32'(burst_done), 32'(e_done));
    if (e_wr && fifo_full) m_ovf = 1'b1;
    pop_seen = ch_pop;
    obs_busy += int'(busy);
    obs_done += int'(burst_done);
    obs_wr   += int'(fifo_wr_en);
    obs_pop  += $countones(ch_pop);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) if (pop_seen[i]) src_cnt[i]++;
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_obs();
    obs_busy = 0; obs_pop = 0; obs_done = 0; obs_wr = 0;
    hdr_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ch_pop", 32'(ch_pop), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(burst_done), 32'd0);
    check("rst_overflow", 32'(overflow_err), 32'd0);
    m_left = 0; m_last = NUM_CH - 1; m_ovf = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int v;
    rst = 1'b0; enable = 1'b0; req = '0; fifo_count = '0; fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin src_cnt[i] = 0; m_cnt[i] = 0; end
    m_left = 0; m_sel = 0; m_last = NUM_CH - 1; m_ovf = 1'b0;
    #2;
    do_reset();

    // Single burst from channel 0.
    clear_obs();
    enable = 1'b1; req = 4'b0001; fifo_count = '0;
    cycle();
    req = '0;
    cycles(11);
    check("t1_busy_cycles", 32'(obs_busy), 32'd10);
    check("t1_pops", 32'(obs_pop), 32'd8);
    check("t1_done_pulses", 32'(obs_done), 32'd1);
    check("t1_writes", 32'(obs_wr), 32'd9);

    // Full rotation from reset.
    do_reset();
    clear_obs();
    req = 4'b1111;
    cycles(5 * (BL + 3));
    req = '0;
    cycles(BL + 3);
    check("t2_hdr_count", 32'(hdr_q.size()), 32'd5);
    if (hdr_q.size() >= 5) begin
      check("t2_hdr0", 32'(hdr_q[0]), 32'hA0);
      check("t2_hdr1", 32'(hdr_q[1]), 32'hA1);
      check("t2_hdr2", 32'(hdr_q[2]), 32'hA2);
      check("t2_hdr3", 32'(hdr_q[3]), 32'hA3);
      check("t2_hdr4", 32'(hdr_q[4]), 32'hA0);
    end

    // Space boundary: 8 free bytes is not enough, 9 is.
    clear_obs();
    req = 4'b0010; fifo_count = 9'd248;
    cycles(5);
    check("t3_no_write", 32'(obs_wr), 32'd0);
    fifo_count = 9'd247;
    cycle();
    req = '0;
    cycle();
    check("t3_grant", 32'(grant), 32'b0010);
    cycles(BL + 2);
    check("t3_hdr", (hdr_q.size() > 0) ? 32'(hdr_q[0]) : 32'hFFFF, 32'hA1);
    fifo_count = '0;

    // Reset in the middle of a ch2 burst restores ch0 priority.
    req = 4'b0100;
    cycles(4);
    do_reset();
    clear_obs();
    req = 4'b0101;
    cycle();
    req = '0;
    cycles(BL + 3);
    check("t4_hdr", (hdr_q.size() > 0) ? 32'(hdr_q[0]) : 32'hFFFF, 32'hA0);

    // enable drops on the second data beat.
    clear_obs();
    req = 4'b1111;
    cycles(3);
    enable = 1'b0;
    cycles(3 * (BL + 3));
    check("t5_writes", 32'(obs_wr), 32'd9);
    check("t5_done", 32'(obs_done), 32'd1);
    enable = 1'b1; req = '0;

    // fifo_full during the header write sets the sticky error.
    req = 4'b0001;
    cycle();
    req = '0;
    fifo_full = 1'b1;
    cycle();
    fifo_full = 1'b0;
    cycles(BL + 4);
    check("t6_overflow_sticky", 32'(overflow_err), 32'd1);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      req    = NUM_CH'($urandom_range(0, 15));
      enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       v = 0;
        1:       v = 247;
        2:       v = 248;
        3:       v = int'($urandom_range(0, 256));
        4:       v = int'($urandom_range(257, 511));
        default: v = int'($urandom_range(0, 240));
      endcase
      fifo_count = CNT_W'(v);
      cycle();
    end
    req = '0;
    cycles(BL + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
